// File: rtl/mul_seq_booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier:
// default width, FSM state encoding and Booth recoding of {Q[0], q_1}.
package mul_seq_booth_pkg;

  localparam int MUL_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_e;

  function automatic booth_op_e booth_decode(input logic q0, input logic q_1);
    case ({q0, q_1})
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/mul_seq_booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then an
// arithmetic right shift of {A, Q, q_1}. Holds the only adder of the design.
module mul_seq_booth_step
  import mul_seq_booth_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] m_i,
  input  logic             q0_i,
  input  logic             q_1_i,
  output logic [WIDTH:0]   acc_o,
  output logic             q_msb_o,
  output logic             q_1_o
);

  logic signed [WIDTH:0] m_sx;
  logic signed [WIDTH:0] acc_s;
  logic signed [WIDTH:0] sum;

  // A carries one guard bit so subtracting the most negative M cannot wrap.
  assign m_sx  = {m_i[WIDTH-1], m_i};
  assign acc_s = acc_i;

  always_comb begin
    sum = acc_s;
    case (booth_decode(q0_i, q_1_i))
      BOOTH_ADD: sum = acc_s + m_sx;
      BOOTH_SUB: sum = acc_s - m_sx;
      default:   sum = acc_s;
    endcase
  end

  assign acc_o   = {sum[WIDTH], sum[WIDTH:1]};
  assign q_msb_o = sum[0];
  assign q_1_o   = q0_i;

endmodule

// File: rtl/mul_seq_booth.sv
// Multi-cycle signed multiplier: FSM, iteration counter and operand/result
// registers around a single Booth step slice. WIDTH+2 cycles per product.
module mul_seq_booth
  import mul_seq_booth_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH:0]       acc_q, acc_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   out_q, out_d;

  logic [WIDTH:0]       acc_nx;
  logic                 qin_nx;
  logic                 qm1_nx;
  logic [WIDTH-1:0]     q_nx;

  mul_seq_booth_step #(.WIDTH(WIDTH)) u_step (
    .acc_i   (acc_q),
    .m_i     (m_q),
    .q0_i    (q_q[0]),
    .q_1_i   (qm1_q),
    .acc_o   (acc_nx),
    .q_msb_o (qin_nx),
    .q_1_o   (qm1_nx)
  );

  assign q_nx = {qin_nx, q_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    out_d   = out_q;
    case (state_q)
      IDLE, DONE: begin
        busy_d = 1'b0;
        if (state_q == DONE) state_d = IDLE;
        // Operands are captured on the accepting edge, so later a/b changes are ignored.
        if (start) begin
          state_d = LOAD;
          busy_d  = 1'b1;
          m_d     = a;
          acc_d   = '0;
          q_d     = b;
          qm1_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      LOAD: state_d = CALC;
      CALC: begin
        acc_d = acc_nx;
        q_d   = q_nx;
        qm1_d = qm1_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          out_d   = {acc_nx[WIDTH-1:0], q_nx};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_mul_seq_booth.sv
// Self-checking bench for mul_seq_booth: directed scenarios plus exhaustive
// and randomized operands against an integer-arithmetic reference.
module tb_mul_seq_booth;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  a;
  logic [5:0]  b;
  logic        busy;
  logic        done;
  logic [11:0] out;

  int checks;
  int errors;

  mul_seq_booth dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] ref_mul(input int x, input int y);
    return 12'(x * y);
  endfunction

  function automatic int sx6(input logic [5:0] v);
    return int'($signed(v));
  endfunction

  // Issue one op from idle; report result, latency (0 = timeout) and busy cycles.
  task automatic do_op(input logic [5:0] ai, input logic [5:0] bi,
                       output logic [11:0] prod, output int cyc,
                       output int bcnt, output logic bdone);
    @(posedge clk); #1;
    a = ai; b = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 6'($urandom);
    b = 6'($urandom);
    cyc = 0; bcnt = 0; prod = '0; bdone = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        cyc = i; prod = out; bdone = busy;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 12'h000) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b out=%h required 0 0 000", busy, done, out);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_basic;
    logic [11:0] p; int cyc; int bc; logic bd;
    do_op(6'd3, 6'd5, p, cyc, bc, bd);
    checks++;
    if (p !== 12'b0000_0000_1111) begin
      errors++; $display("FAIL basic_3x5 out=%h required %h", p, 12'h00F);
    end
    checks++;
    if (cyc !== 8) begin
      errors++; $display("FAIL basic_latency cycles=%0d required 8", cyc);
    end
    checks++;
    if (bc !== 7) begin
      errors++; $display("FAIL basic_busy_cycles busy=%0d required 7", bc);
    end
    checks++;
    if (bd !== 1'b0) begin
      errors++; $display("FAIL busy_in_done busy=%b required 0", bd);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || out !== 12'h00F) begin
      errors++; $display("FAIL done_pulse_hold done=%b out=%h required 0 00F", done, out);
    end
  endtask

  task automatic test_extremes;
    logic [5:0]  ta [4] = '{6'h20, 6'h20, 6'h3F, 6'h00};
    logic [5:0]  tb [4] = '{6'h20, 6'h1F, 6'h01, 6'h2F};
    logic [11:0] te [4] = '{12'h400, 12'hC20, 12'hFFF, 12'h000};
    logic [11:0] p; int cyc; int bc; logic bd;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], p, cyc, bc, bd);
      checks++;
      if (p !== te[i] || cyc !== 8) begin
        errors++;
        $display("FAIL extreme_%0d out=%h cycles=%0d required %h 8", i, p, cyc, te[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] first; int got; int cyc;
    first = ref_mul(-5, 9);
    @(posedge clk); #1;
    a = 6'h3B; b = 6'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1; a = 6'd7; b = 6'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 0;
    for (int i = 5; i <= 25; i++) begin
      @(negedge clk);
      if (done) begin got = i; break; end
    end
    checks++;
    if (got !== 8 || out !== first) begin
      errors++;
      $display("FAIL ignore_busy_start cycles=%0d out=%h required 8 %h", got, out, first);
    end
    // Hold start through the DONE cycle so the next op starts without a gap.
    a = 6'd2; b = 6'h3D; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 6'($urandom); b = 6'($urandom);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || out !== first) begin
      errors++;
      $display("FAIL b2b_accept busy=%b out=%h required 1 %h", busy, out, first);
    end
    cyc = 0;
    for (int i = 2; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin cyc = i; break; end
    end
    checks++;
    if (cyc !== 8 || out !== ref_mul(2, -3)) begin
      errors++;
      $display("FAIL b2b_second cycles=%0d out=%h required 8 %h", cyc, out, ref_mul(2, -3));
    end
    got = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) got++;
    end
    checks++;
    if (got !== 0) begin
      errors++; $display("FAIL no_queued_op active_cycles=%0d required 0", got);
    end
  endtask

  task automatic test_reset_mid_calc;
    int seen;
    @(posedge clk); #1;
    a = 6'd5; b = 6'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2; rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_calc busy=%b done=%b out=%h required 0 0 000", busy, done, out);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++;
    if (seen !== 0 || out !== 12'h000) begin
      errors++;
      $display("FAIL no_done_after_reset pulses=%0d out=%h required 0 000", seen, out);
    end
  endtask

  task automatic test_exhaustive;
    logic [11:0] p; int cyc; int bc; logic bd;
    for (int x = -32; x < 32; x++) begin
      for (int y = -32; y < 32; y++) begin
        do_op(6'(x), 6'(y), p, cyc, bc, bd);
        checks++;
        if (p !== ref_mul(x, y) || cyc !== 8) begin
          errors++;
          $display("FAIL exhaustive %0d*%0d out=%h cycles=%0d required %h 8",
                   x, y, p, cyc, ref_mul(x, y));
        end
      end
    end
  endtask

  task automatic test_random;
    logic [11:0] p; int cyc; int bc; logic bd;
    logic [5:0] ra; logic [5:0] rb;
    for (int i = 0; i < 200; i++) begin
      ra = 6'($urandom);
      rb = 6'($urandom);
      do_op(ra, rb, p, cyc, bc, bd);
      checks++;
      if (p !== ref_mul(sx6(ra), sx6(rb)) || bc !== 7) begin
        errors++;
        $display("FAIL random %0d*%0d out=%h busy=%0d required %h 7",
                 sx6(ra), sx6(rb), p, bc, ref_mul(sx6(ra), sx6(rb)));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_extremes();
    test_back_to_back();
    test_reset_mid_calc();
    test_exhaustive();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
